mc_ctrl: RTL and testbench

- Multicycle main control FSM for the MIPS core.
- Sequences the instruction fetch unit, register file, ALU, data memory and CP0 for every instruction.
- Generates the fetch unit's PC-write enable and next-PC select, the instruction-register write, and the datapath/CP0 strobes.
- Samples the external interrupt at instruction boundaries and runs the interrupt-entry cycle.

---
 rtl/mc_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM for the MIPS core: sequences fetch, decode, ALU,
// memory, write-back, branch/jump and interrupt entry for each instruction.
//
//  state  | meaning
//  FETCH  | load IR from memory, PC <= PC+4
//  DECODE | register read, dispatch on op/rs/funct
//  EXE    | ALU operation
//  MEM    | data memory access (lw read, sw write)
//  WB     | GPR or CP0 write-back
//  BR     | beq: PC <= branch target when zero
//  JMP    | j/jal/jr/eret
//  INT    | interrupt entry: EPC <= PC, EXL <= 1, PC <= vector
module mc_ctrl #(
    parameter logic [2:0] NPC_PC4 = 3'd0,
    parameter logic [2:0] NPC_REG = 3'd1,
    parameter logic [2:0] NPC_J   = 3'd2,
    parameter logic [2:0] NPC_BEQ = 3'd3,
    parameter logic [2:0] NPC_INT = 3'd4,
    parameter bit         INT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       int_req,
    input  logic       ie,
    input  logic       exl,
    output logic       pc_wr,
    output logic [2:0] npc_sel,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       mem_wr,
    output logic       cp0_wr,
    output logic       epc_wr,
    output logic       exl_set,
    output logic       exl_clr,
    output logic       regpc_sel,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_BR     = 4'd5,
        S_JMP    = 4'd6,
        S_INT    = 4'd7
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_wr;
        logic       cp0_wr;
        logic       epc_wr;
        logic       exl_set;
        logic       exl_clr;
        logic       regpc_sel;
    } ctl_t;

    state_t st;
    ctl_t   ctl_q;
    ctl_t   ctl_o;

    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_eret, is_mfc0, is_mtc0, take_int;

    assign is_addu  = (op == 6'h00) && (funct == 6'h21);
    assign is_subu  = (op == 6'h00) && (funct == 6'h23);
    assign is_jr    = (op == 6'h00) && (funct == 6'h08);
    assign is_ori   = (op == 6'h0D);
    assign is_lui   = (op == 6'h0F);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_eret  = (op == 6'h10) && (rs == 5'h10) && (funct == 6'h18);
    assign is_mfc0  = (op == 6'h10) && (rs == 5'h00);
    assign is_mtc0  = (op == 6'h10) && (rs == 5'h04);
    // exl is the live input, so an eret clearing EXL cannot trigger entry in its own cycle
    assign take_int = INT_EN && int_req && ie && !exl;

    function automatic state_t next_state(input state_t s);
        state_t boundary;
        boundary = take_int ? S_INT : S_FETCH;
        case (s)
            S_FETCH:  return S_DECODE;
            S_DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui || is_lw || is_sw)
                    return S_EXE;
                else if (is_beq)
                    return S_BR;
                else if (is_j || is_jal || is_jr || is_eret)
                    return S_JMP;
                else if (is_mfc0 || is_mtc0)
                    return S_WB;
                else
                    return boundary;
            end
            S_EXE:    return (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:    return is_lw ? S_WB : boundary;
            S_INT:    return S_FETCH;
            default:  return boundary;
        endcase
    endfunction

    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_wr   = 1'b1;
                c.pc_wr   = 1'b1;
                c.npc_sel = NPC_PC4;
            end
            S_EXE: begin
                c.alu_op  = is_subu ? 2'd1 : is_ori ? 2'd2 : is_lui ? 2'd3 : 2'd0;
                c.alu_src = is_ori || is_lui || is_lw || is_sw;
                c.ext_op  = is_lw || is_sw;
            end
            S_MEM:   c.mem_wr = is_sw;
            S_WB: begin
                c.reg_wr  = !is_mtc0;
                c.cp0_wr  = is_mtc0;
                c.reg_dst = (is_addu || is_subu) ? 2'd1 : 2'd0;
                c.wd_sel  = is_lw ? 2'd1 : is_mfc0 ? 2'd3 : 2'd0;
            end
            S_BR:    c.npc_sel = NPC_BEQ;
            S_JMP: begin
                c.pc_wr   = 1'b1;
                c.npc_sel = (is_j || is_jal) ? NPC_J : NPC_REG;
                if (is_jal) begin
                    c.reg_wr  = 1'b1;
                    c.reg_dst = 2'd2;
                    c.wd_sel  = 2'd2;
                end
                c.regpc_sel = is_eret;
                c.exl_clr   = is_eret;
            end
            S_INT: begin
                c.pc_wr   = 1'b1;
                c.npc_sel = NPC_INT;
                c.epc_wr  = 1'b1;
                c.exl_set = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Strobes are precomputed for the state being entered; IR is stable from DECODE on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= S_FETCH;
            ctl_q <= ctl_for(S_FETCH);
        end else begin
            st    <= next_state(st);
            ctl_q <= ctl_for(next_state(st));
        end
    end

    assign ctl_o     = reset ? '0 : ctl_q;
    // The branch decision follows the live comparator result during BR.
    assign pc_wr     = !reset && (ctl_o.pc_wr || ((st == S_BR) && zero));
    assign npc_sel   = ctl_o.npc_sel;
    assign ir_wr     = ctl_o.ir_wr;
    assign reg_wr    = ctl_o.reg_wr;
    assign reg_dst   = ctl_o.reg_dst;
    assign wd_sel    = ctl_o.wd_sel;
    assign alu_src   = ctl_o.alu_src;
    assign alu_op    = ctl_o.alu_op;
    assign ext_op    = ctl_o.ext_op;
    assign mem_wr    = ctl_o.mem_wr;
    assign cp0_wr    = ctl_o.cp0_wr;
    assign epc_wr    = ctl_o.epc_wr;
    assign exl_set   = ctl_o.exl_set;
    assign exl_clr   = ctl_o.exl_clr;
    assign regpc_sel = ctl_o.regpc_sel;
    assign state     = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of instructions plus random instruction stream,
// each cycle compared against an instruction-level model of the control sequence.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [4:0] rs;
    logic [5:0] funct;
    logic       zero, int_req, ie, exl;
    logic       pc_wr, ir_wr, reg_wr, alu_src, ext_op, mem_wr, cp0_wr;
    logic       epc_wr, exl_set, exl_clr, regpc_sel;
    logic [2:0] npc_sel;
    logic [1:0] reg_dst, wd_sel, alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .rs(rs), .funct(funct), .zero(zero),
        .int_req(int_req), .ie(ie), .exl(exl), .pc_wr(pc_wr), .npc_sel(npc_sel),
        .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr),
        .cp0_wr(cp0_wr), .epc_wr(epc_wr), .exl_set(exl_set), .exl_clr(exl_clr),
        .regpc_sel(regpc_sel), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_wr;
        logic       cp0_wr;
        logic       epc_wr;
        logic       exl_set;
        logic       exl_clr;
        logic       regpc_sel;
    } ov_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [4:0] rs;
        logic [5:0] funct;
        logic       zero;
        logic [7:0] irqb;
        logic       ie;
        logic       exl;
        int         cyc;
    } vec_t;

    localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_ERET = 10;
    localparam int C_MFC0 = 11, C_MTC0 = 12, C_NOP = 13;

    int path_q[$];

    function automatic int classify(input logic [5:0] o, input logic [4:0] r, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h21) ? C_ADDU : (f == 6'h23) ? C_SUBU : (f == 6'h08) ? C_JR : C_NOP;
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            6'h10:   return (r == 5'h10 && f == 6'h18) ? C_ERET : (r == 5'h00) ? C_MFC0 :
                            (r == 5'h04) ? C_MTC0 : C_NOP;
            default: return C_NOP;
        endcase
    endfunction

    // Phase sequence of each instruction class (state codes), before any interrupt entry.
    task automatic build_path(input int cls);
        path_q.delete();
        case (cls)
            C_ADDU, C_SUBU, C_ORI, C_LUI: path_q = '{0, 1, 2, 4};
            C_LW:                         path_q = '{0, 1, 2, 3, 4};
            C_SW:                         path_q = '{0, 1, 2, 3};
            C_BEQ:                        path_q = '{0, 1, 5};
            C_J, C_JAL, C_JR, C_ERET:     path_q = '{0, 1, 6};
            C_MFC0, C_MTC0:               path_q = '{0, 1, 4};
            default:                      path_q = '{0, 1};
        endcase
    endtask

    function automatic ov_t exp_out(input int st, input int cls, input logic z);
        ov_t e;
        e = '0;
        case (st)
            0: begin e.pc_wr = 1; e.ir_wr = 1; e.npc_sel = 3'd0; end
            2: begin
                e.alu_op  = (cls == C_SUBU) ? 2'd1 : (cls == C_ORI) ? 2'd2 : (cls == C_LUI) ? 2'd3 : 2'd0;
                e.alu_src = (cls == C_ORI || cls == C_LUI || cls == C_LW || cls == C_SW);
                e.ext_op  = (cls == C_LW || cls == C_SW);
            end
            3: e.mem_wr = (cls == C_SW);
            4: begin
                if (cls == C_MTC0) e.cp0_wr = 1; else e.reg_wr = 1;
                e.reg_dst = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
                e.wd_sel  = (cls == C_LW) ? 2'd1 : (cls == C_MFC0) ? 2'd3 : 2'd0;
            end
            5: begin e.npc_sel = 3'd3; e.pc_wr = z; end
            6: begin
                e.pc_wr = 1;
                if (cls == C_J) e.npc_sel = 3'd2;
                if (cls == C_JAL) begin e.npc_sel = 3'd2; e.reg_wr = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
                if (cls == C_JR) e.npc_sel = 3'd1;
                if (cls == C_ERET) begin e.npc_sel = 3'd1; e.regpc_sel = 1; e.exl_clr = 1; end
            end
            7: begin e.pc_wr = 1; e.npc_sel = 3'd4; e.epc_wr = 1; e.exl_set = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ov_t dut_outs();
        ov_t v;
        v.pc_wr = pc_wr;     v.npc_sel = npc_sel; v.ir_wr = ir_wr;     v.reg_wr = reg_wr;
        v.reg_dst = reg_dst; v.wd_sel = wd_sel;   v.alu_src = alu_src; v.alu_op = alu_op;
        v.ext_op = ext_op;   v.mem_wr = mem_wr;   v.cp0_wr = cp0_wr;   v.epc_wr = epc_wr;
        v.exl_set = exl_set; v.exl_clr = exl_clr; v.regpc_sel = regpc_sel;
        return v;
    endfunction

    task automatic check_vec(input string nm, input int step, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got state/outs %h, expected %h", nm, step, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Starts with the DUT in FETCH just after a clock edge; ends likewise.
    task automatic run_instr(input string nm, input logic [5:0] o, input logic [4:0] r,
                             input logic [5:0] f, input logic z, input logic [7:0] irqb,
                             input logic ie_v, input logic exl_v, input int exp_cyc);
        int cls, n, cyc, es;
        ov_t e;
        cls = classify(o, r, f);
        build_path(cls);
        n = path_q.size();
        if (irqb[n-1] && ie_v && !exl_v) path_q.push_back(7);
        op = o; rs = r; funct = f; zero = z; ie = ie_v; exl = exl_v;
        cyc = 12;
        for (int i = 0; i < 12; i++) begin
            int_req = (i < 8) ? irqb[i] : 1'b0;
            @(negedge clk);
            es = (i < path_q.size()) ? path_q[i] : 15;
            e  = (i < path_q.size()) ? exp_out(es, cls, z) : '0;
            check_vec(nm, i, {state, dut_outs()}, {es[3:0], e});
            @(posedge clk);
            #1;
            if (state == 4'd0) begin
                cyc = i + 1;
                break;
            end
        end
        check_int({nm, " cycles"}, cyc, (exp_cyc >= 0) ? exp_cyc : path_q.size());
        int_req = 1'b0;
    endtask

    vec_t tbl[$];
    logic [5:0] kop[13];
    logic [4:0] krs[13];
    logic [5:0] kfn[13];

    initial begin
        reset = 1'b1; op = 6'h00; rs = 5'h00; funct = 6'h21;
        zero = 1'b0; int_req = 1'b0; ie = 1'b0; exl = 1'b0;

        tbl.push_back('{"addu",         6'h00, 5'h00, 6'h21, 1'b0, 8'h00, 1'b1, 1'b0, 4});
        tbl.push_back('{"subu",         6'h00, 5'h00, 6'h23, 1'b0, 8'h00, 1'b1, 1'b0, 4});
        tbl.push_back('{"ori",          6'h0D, 5'h03, 6'h11, 1'b0, 8'h00, 1'b1, 1'b0, 4});
        tbl.push_back('{"lui",          6'h0F, 5'h00, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4});
        tbl.push_back('{"lw",           6'h23, 5'h01, 6'h04, 1'b0, 8'h00, 1'b1, 1'b0, 5});
        tbl.push_back('{"sw",           6'h2B, 5'h01, 6'h08, 1'b0, 8'h00, 1'b1, 1'b0, 4});
        tbl.push_back('{"beq_nt",       6'h04, 5'h02, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"beq_t",        6'h04, 5'h02, 6'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"j",            6'h02, 5'h00, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"jal",          6'h03, 5'h00, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"jr",           6'h00, 5'h1F, 6'h08, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"eret_exl",     6'h10, 5'h10, 6'h18, 1'b0, 8'hFF, 1'b1, 1'b1, 3});
        tbl.push_back('{"mfc0",         6'h10, 5'h00, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"mtc0",         6'h10, 5'h04, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3});
        tbl.push_back('{"nop",          6'h3F, 5'h00, 6'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2});
        tbl.push_back('{"ori_int",      6'h0D, 5'h00, 6'h00, 1'b0, 8'hFC, 1'b1, 1'b0, 5});
        tbl.push_back('{"ori_int_exl",  6'h0D, 5'h00, 6'h00, 1'b0, 8'hFC, 1'b1, 1'b1, 4});
        tbl.push_back('{"ori_irq_drop", 6'h0D, 5'h00, 6'h00, 1'b0, 8'h06, 1'b1, 1'b0, 4});
        tbl.push_back('{"addu_ie0",     6'h00, 5'h00, 6'h21, 1'b0, 8'hFF, 1'b0, 1'b0, 4});
        tbl.push_back('{"jal_int",      6'h03, 5'h00, 6'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 4});

        kop = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00, 6'h10, 6'h10, 6'h10};
        krs = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00, 5'h04};
        kfn = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h18, 6'h00, 6'h00};

        // Everything held at zero while reset is asserted, even across clock edges.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_vec("reset", i, {state, dut_outs()}, 26'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i])
            run_instr(tbl[i].nm, tbl[i].op, tbl[i].rs, tbl[i].funct, tbl[i].zero,
                      tbl[i].irqb, tbl[i].ie, tbl[i].exl, tbl[i].cyc);

        // Reset in the middle of a lw abandons it; the next instruction starts clean.
        op = 6'h23; rs = 5'h00; funct = 6'h00; ie = 1'b0; exl = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_int("lw_in_exe", int'(state), 2);
        reset = 1'b1;
        #1;
        check_vec("reset_async", 0, {state, dut_outs()}, 26'd0);
        @(negedge clk);
        check_vec("reset_held", 1, {state, dut_outs()}, 26'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("addu_after_reset", 6'h00, 5'h00, 6'h21, 1'b0, 8'h00, 1'b1, 1'b0, 4);

        for (int k = 0; k < 250; k++) begin
            int sel;
            logic [5:0] ro, rf;
            logic [4:0] rr;
            sel = int'($urandom_range(0, 16));
            if (sel < 13) begin
                ro = kop[sel]; rr = krs[sel]; rf = kfn[sel];
            end else begin
                ro = 6'($urandom); rr = 5'($urandom); rf = 6'($urandom);
            end
            run_instr("random", ro, rr, rf, 1'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
